// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared fetch FSM states and text-segment address-map constants
package mips_fetch_pkg;
    typedef enum logic [2:0] {IDLE, REQ, DISCARD, RESP, FAULT} fetch_state_t;
    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/fetch_addr_xlate.sv
// fetch_addr_xlate: byte address to memory word index with out-of-range and misalignment flags
module fetch_addr_xlate
    import mips_fetch_pkg::*;
#(
    parameter int N_BITS = 32,
    parameter logic [N_BITS-1:0] BASE = TEXT_BASE_DEFAULT,
    parameter int ADDR_W = 8
) (
    input  logic [N_BITS-1:0] addr,
    output logic [ADDR_W-1:0] idx,
    output logic              out_of_range,
    output logic              misaligned
);
    logic [N_BITS-1:0] word;
    assign word = (addr - BASE) >> WORD_SHIFT;
    assign idx = word[ADDR_W-1:0];
    assign out_of_range = (addr < BASE) || (|(word >> ADDR_W));
    assign misaligned = |addr[WORD_SHIFT-1:0];
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC to instruction-memory fetch with valid/ready delivery to decode (MISALIGN_CHECK_EN enables alignment faults)
module instr_fetch_ctrl
    import mips_fetch_pkg::*;
#(
    parameter int N_BITS = 32,
    parameter logic [N_BITS-1:0] TEXT_BASE = TEXT_BASE_DEFAULT,
    parameter int MEM_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_BITS-1:0]     pc_i,
    input  logic                  pc_valid_i,
    output logic                  fetch_ready_o,
    input  logic                  flush_i,
    output logic                  mem_req_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [N_BITS-1:0]     mem_rdata_i,
    output logic [N_BITS-1:0]     instr_o,
    output logic [N_BITS-1:0]     instr_pc_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic                  fault_o
);
`ifdef MISALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif
    fetch_state_t state, state_n;
    logic [MEM_ADDR_W-1:0] idx;
    logic out_of_range, misaligned, bad, accept;
    fetch_addr_xlate #(.N_BITS(N_BITS), .BASE(TEXT_BASE), .ADDR_W(MEM_ADDR_W)) u_xlate (
        .addr(pc_i),
        .idx(idx),
        .out_of_range(out_of_range),
        .misaligned(misaligned)
    );
    assign bad = out_of_range | (ALIGN_CHK & misaligned);
    assign accept = (state == IDLE) && pc_valid_i && !flush_i;
    // State register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_n;
    // Next state and state-decoded handshake outputs
    always_comb begin
        state_n = state;
        fetch_ready_o = state == IDLE;
        mem_req_o = (state == REQ) || (state == DISCARD);
        instr_valid_o = state == RESP;
        case (state)
            IDLE:    state_n = accept ? (bad ? FAULT : REQ) : IDLE;
            REQ:     state_n = mem_ack_i ? (flush_i ? IDLE : RESP) : (flush_i ? DISCARD : REQ);
            DISCARD: state_n = mem_ack_i ? IDLE : DISCARD;
            RESP:    state_n = (instr_ready_i || flush_i) ? IDLE : RESP;
            FAULT:   state_n = flush_i ? IDLE : FAULT;
            default: state_n = IDLE;
        endcase
    end
    // Fetch address, PC tag, returned instruction and sticky fault
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            mem_addr_o <= '0;
            instr_o <= '0;
            instr_pc_o <= '0;
            fault_o <= 1'b0;
        end else begin
            if (accept && bad) fault_o <= 1'b1;
            if (accept && !bad) begin
                mem_addr_o <= idx;
                instr_pc_o <= pc_i;
            end
            if (state == REQ && mem_ack_i && !flush_i) instr_o <= mem_rdata_i;
            if (state == FAULT && flush_i) fault_o <= 1'b0;
        end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: vector table, corner sequences and randomized transactions against a transaction-level model
module tb_instr_fetch_ctrl;
    localparam logic [31:0] BASE = 32'h0040_0000;
`ifdef MISALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_i = '0;
    logic        pc_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic        flush_i = 1'b0;
    logic        mem_req_o;
    logic [7:0]  mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic        fault_o;
    int checks = 0;
    int errors = 0;
    logic [31:0] mem [256];

    typedef struct {
        logic [31:0] pc;
        int          wt;
        int          stall;
        int          fcyc;
        bit          rflush;
        bit          exp_bad;
        logic [7:0]  exp_idx;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    instr_fetch_ctrl #(.N_BITS(32), .TEXT_BASE(BASE), .MEM_ADDR_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .pc_i(pc_i),
        .pc_valid_i(pc_valid_i),
        .fetch_ready_o(fetch_ready_o),
        .flush_i(flush_i),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .instr_o(instr_o),
        .instr_pc_o(instr_pc_o),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .fault_o(fault_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit model_bad(input logic [31:0] pc);
        if (pc < BASE) return 1'b1;
        if ((pc - BASE) / 4 >= 256) return 1'b1;
        return ALIGN_EN && (pc % 4 != 0);
    endfunction

    function automatic logic [7:0] model_idx(input logic [31:0] pc);
        logic [31:0] w;
        w = (pc - BASE) / 4;
        return w[7:0];
    endfunction

    task automatic run(input vec_t v);
        logic [31:0] data;
        chk("idle_ready", fetch_ready_o, 1);
        pc_i = v.pc;
        pc_valid_i = 1'b1;
        step();
        pc_valid_i = 1'b0;
        pc_i = $urandom;
        if (v.exp_bad) begin
            for (int c = 0; c < 3; c++) begin
                chk("fault_flag", fault_o, 1);
                chk("fault_noreq", mem_req_o, 0);
                chk("fault_ready", fetch_ready_o, 0);
                chk("fault_novalid", instr_valid_o, 0);
                pc_valid_i = (c % 2 == 1);
                pc_i = BASE;
                step();
            end
            pc_valid_i = 1'b0;
            flush_i = 1'b1;
            step();
            flush_i = 1'b0;
            chk("fault_clear", fault_o, 0);
            chk("fault_exit_ready", fetch_ready_o, 1);
            return;
        end
        data = mem[v.exp_idx];
        for (int c = 0; c <= v.wt; c++) begin
            chk("req", mem_req_o, 1);
            chk("addr", mem_addr_o, v.exp_idx);
            chk("busy_ready", fetch_ready_o, 0);
            chk("req_novalid", instr_valid_o, 0);
            mem_ack_i = (c == v.wt);
            mem_rdata_i = mem_ack_i ? data : $urandom;
            flush_i = (c == v.fcyc);
            step();
        end
        mem_ack_i = 1'b0;
        flush_i = 1'b0;
        mem_rdata_i = $urandom;
        if (v.fcyc >= 0) begin
            chk("flushed_novalid", instr_valid_o, 0);
            chk("flushed_noreq", mem_req_o, 0);
            chk("flushed_ready", fetch_ready_o, 1);
            return;
        end
        for (int s = 0; s <= v.stall; s++) begin
            chk("valid", instr_valid_o, 1);
            chk("instr", instr_o, data);
            chk("instr_pc", instr_pc_o, v.pc);
            chk("resp_ready", fetch_ready_o, 0);
            chk("resp_noreq", mem_req_o, 0);
            instr_ready_i = (s == v.stall);
            if (v.rflush && s == v.stall) begin
                flush_i = 1'b1;
                instr_ready_i = $urandom_range(0, 1) == 1;
            end
            step();
        end
        instr_ready_i = 1'b0;
        flush_i = 1'b0;
        chk("done_novalid", instr_valid_o, 0);
        chk("done_ready", fetch_ready_o, 1);
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;
        vecs.push_back('{32'h0040_0000, 0, 0, -1, 1'b0, 1'b0, 8'd0});
        vecs.push_back('{32'h0040_0010, 3, 0, -1, 1'b0, 1'b0, 8'd4});
        vecs.push_back('{32'h0040_0020, 0, 5, -1, 1'b0, 1'b0, 8'd8});
        vecs.push_back('{32'h0040_0400, 0, 0, -1, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{32'h003F_FFFC, 0, 0, -1, 1'b0, 1'b1, 8'd0});
        vecs.push_back('{32'h0040_03FC, 1, 0, -1, 1'b0, 1'b0, 8'd255});
        vecs.push_back('{32'h0040_0008, 3, 0, 1, 1'b0, 1'b0, 8'd2});
        vecs.push_back('{32'h0040_0024, 0, 0, -1, 1'b0, 1'b0, 8'd9});
        vecs.push_back('{32'h0040_000C, 2, 0, 2, 1'b0, 1'b0, 8'd3});
        vecs.push_back('{32'h0040_0014, 1, 2, -1, 1'b1, 1'b0, 8'd5});
        vecs.push_back('{32'h0040_0002, 0, 0, -1, 1'b0, ALIGN_EN, 8'd0});
        vecs.push_back('{32'hFFFF_FFFC, 0, 0, -1, 1'b0, 1'b1, 8'd0});
        repeat (2) @(negedge clk);
        chk("rst_state_ready", fetch_ready_o, 1);
        chk("rst_req", mem_req_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_instr_pc", instr_pc_o, 0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_fault", fault_o, 0);
        reset = 1'b1;
        step();
        chk("post_rst_ready", fetch_ready_o, 1);
        foreach (vecs[i]) run(vecs[i]);
        pc_i = BASE;
        pc_valid_i = 1'b1;
        flush_i = 1'b1;
        step();
        pc_valid_i = 1'b0;
        flush_i = 1'b0;
        chk("flush_blocks_accept_req", mem_req_o, 0);
        chk("flush_blocks_accept_ready", fetch_ready_o, 1);
        pc_i = BASE + 32'h8;
        pc_valid_i = 1'b1;
        step();
        pc_valid_i = 1'b0;
        chk("midrst_pre_req", mem_req_o, 1);
        chk("midrst_pre_addr", mem_addr_o, 2);
        reset = 1'b0;
        #1;
        chk("midrst_req", mem_req_o, 0);
        chk("midrst_addr", mem_addr_o, 0);
        chk("midrst_ready", fetch_ready_o, 1);
        chk("midrst_instr_pc", instr_pc_o, 0);
        step();
        reset = 1'b1;
        pc_i = 32'h0040_0400;
        pc_valid_i = 1'b1;
        step();
        pc_valid_i = 1'b0;
        chk("fltrst_pre_fault", fault_o, 1);
        reset = 1'b0;
        #1;
        chk("fltrst_fault", fault_o, 0);
        chk("fltrst_ready", fetch_ready_o, 1);
        step();
        reset = 1'b1;
        step();
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 4) == 0) v.pc = $urandom;
            else v.pc = BASE + ($urandom_range(0, 255) * 4) + (($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0);
            v.wt = $urandom_range(0, 4);
            v.stall = $urandom_range(0, 3);
            v.fcyc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, v.wt) : -1;
            v.rflush = $urandom_range(0, 6) == 0;
            v.exp_bad = model_bad(v.pc);
            v.exp_idx = model_idx(v.pc);
            run(v);
            repeat ($urandom_range(0, 2)) step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Consumer side of the program counter interface.
- Accepts the PC value, converts the MIPS byte address (text segment at 0x0040_0000) into a word index and runs a request/acknowledge read on the instruction memory.
- Presents the returned instruction to the decode stage with a valid/ready handshake.
- Sits between the Program Counter register and instruction memory. Supports variable-latency memories and back-pressure from decode.

Parameters:
- N_BITS, 32, width of PC and instruction words.
- TEXT_BASE, 32'h0040_0000, byte address mapped to memory word 0.
- MEM_ADDR_W, 8, word-index width; memory holds 2**MEM_ADDR_W words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-low.
- pc_i  in  N_BITS  PC byte address from the Program Counter.
- pc_valid_i  in  1  pc_i holds a new fetch address.
- fetch_ready_o  out  1  block can accept a PC this cycle; also the PC stall (hold when 0).
- flush_i  in  1  discard the in-flight fetch (branch/jump redirect).
- mem_req_o  out  1  read request to instruction memory.
- mem_addr_o  out  MEM_ADDR_W  word index for the memory.
- mem_ack_i  in  1  memory has data on mem_rdata_i this cycle.
- mem_rdata_i  in  N_BITS  instruction word from memory.
- instr_o  out  N_BITS  fetched instruction.
- instr_pc_o  out  N_BITS  PC of instr_o.
- instr_valid_o  out  1  instr_o/instr_pc_o are valid.
- instr_ready_i  in  1  decode accepts the instruction.
- fault_o  out  1  sticky out-of-range (or misaligned) fetch fault.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE.
  - mem_req_o=0, mem_addr_o=0.
  - instr_o=0, instr_pc_o=0, instr_valid_o=0.
  - fault_o=0, fetch_ready_o=1.
- Address translation (combinational): idx=(pc_i-TEXT_BASE)>>2.
  - Out of range when pc_i<TEXT_BASE or idx>=2**MEM_ADDR_W.
  - mem_addr_o is idx[MEM_ADDR_W-1:0], registered at accept.
- FSM states: IDLE, REQ, DISCARD, RESP, FAULT.
- IDLE: fetch_ready_o=1.
  - On pc_valid_i & !flush_i:
    - In range: latch addr and PC, go to REQ.
    - Out of range: set fault_o, go to FAULT.
- REQ: mem_req_o=1, mem_addr_o stable.
  - On mem_ack_i: capture mem_rdata_i into instr_o, set instr_valid_o, go to RESP.
  - On flush_i without ack: go to DISCARD (a request cannot be withdrawn).
  - flush_i in the same cycle as mem_ack_i: data dropped, go to IDLE.
- DISCARD: mem_req_o=1 until mem_ack_i; data dropped; then IDLE.
- RESP: instr_valid_o=1; instr_o/instr_pc_o held stable until instr_ready_i.
  - On instr_ready_i: clear valid, go to IDLE.
  - flush_i in RESP: clear valid, go to IDLE (no transfer even if instr_ready_i=1).
- FAULT: fetch_ready_o=0, no memory traffic; leave only on flush_i, which clears fault_o and returns to IDLE.
- fetch_ready_o=1 only in IDLE, so at most one fetch is in flight and the PC holds otherwise.
- Latency: accept at edge N; mem_req_o high from N+1.
  - With zero-wait memory (ack in the first REQ cycle), instr_valid_o is high at N+2.
  - Each wait cycle adds one.
- Reset asserted mid-operation: immediate return to reset values; the memory must tolerate a dropped request.

Optional Feature:
- MISALIGN_CHECK_EN defined: pc_i[1:0]!=0 at accept is a fault (same FAULT path as out-of-range).
- Undefined: pc_i[1:0] ignored, address truncated to a word.

Decomposition:
- Package mips_fetch_pkg holds:
  - the FSM state enum (fetch_state_t);
  - TEXT_BASE_DEFAULT = 32'h0040_0000;
  - localparam WORD_SHIFT = 2.
- Sub-module fetch_addr_xlate (combinational: pc to word index plus range/misalign flags). Instantiated once, reusable for data memory.

Test Plan:
- Reset, then pc_i=0x0040_0000, zero-wait memory returning 0x2008_0005 → mem_addr_o=0, instr_o=0x2008_0005, instr_pc_o=0x0040_0000, valid 2 cycles after accept.
- pc_i=0x0040_0010, ack after 3 wait cycles → mem_req_o high 4 cycles with mem_addr_o=4; fetch_ready_o=0 throughout.
- instr_ready_i held 0 for 5 cycles in RESP → instr_o stable, fetch_ready_o=0, no new mem_req_o; transfer on the cycle ready rises.
- pc_i=0x0040_0400 with MEM_ADDR_W=8 → fault_o=1, no mem_req_o. Then flush_i → fault_o=0, IDLE.
- flush_i during REQ before ack → DISCARD; the ack is consumed and instr_valid_o never rises; the next PC is accepted afterward.
- With MISALIGN_CHECK_EN, pc_i=0x0040_0002 → fault_o=1. Without it → mem_addr_o=0, normal fetch.
